// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - DEPTH-slot valid/ready pipeline register chain with hold, flush and bubble collapse
module elastic_pipe_reg #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  adv;
  logic [CW-1:0]     count_d;
  logic              move;
  logic              in_fire;

  // A slot may advance when downstream drains or any slot at/after it is a bubble;
  // written as a reduction rather than a ripple chain to keep the comb path flat.
  for (genvar i = 0; i < DEPTH; i++) begin : g_adv
    assign adv[i] = out_ready | ~(&valid_q[DEPTH-1:i]);
  end

  assign move      = en & ~flush;
  assign in_ready  = nRST & move & adv[0];
  assign in_fire   = in_valid & in_ready;
  assign out_valid = valid_q[DEPTH-1] & move;
  assign out_data  = data_q[DEPTH-1];

  always_comb begin
    valid_d = valid_q;
    count_d = '0;
    if (flush) begin
      valid_d = '0;
    end else if (en) begin
      if (adv[0]) valid_d[0] = in_fire;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) valid_d[i] = valid_q[i-1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  // Payload only moves with a live source; a slot overtaken by a bubble keeps its old bits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
      valid_q <= '0;
      count   <= '0;
    end else begin
      valid_q <= valid_d;
      count   <= count_d;
      if (move) begin
        if (in_fire) data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          if (adv[i] && valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - directed vector bench for elastic_pipe_reg at DEPTH 3, 4 and 2
module tb_elastic_pipe_reg;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       en, flush, in_valid, out_ready;
  logic [7:0] in_data;

  logic       ir3, ov3, ir4, ov4, ir2, ov2;
  logic [7:0] od3, od4, od2;
  logic [1:0] cnt3, cnt2;
  logic [2:0] cnt4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  elastic_pipe_reg #(.DATA_W(8), .DEPTH(3), .RESET_VAL(8'hEE)) u3 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .count(cnt3));

  elastic_pipe_reg #(.DATA_W(8), .DEPTH(4), .RESET_VAL(8'hEE)) u4 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .count(cnt4));

  elastic_pipe_reg #(.DATA_W(8), .DEPTH(2), .RESET_VAL(8'hEE)) u2 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(cnt2));

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                      input logic e, input logic fl);
    @(negedge CLK);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    en        = e;
    flush     = fl;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // DEPTH=3: back-to-back push with out_ready=1, then fill/stall/release
    vecs[0]  = '{1'b1, 8'h0A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 2'd0};
    vecs[1]  = '{1'b1, 8'h0B, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 2'd1};
    vecs[2]  = '{1'b1, 8'h0C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE, 2'd2};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd3};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0B, 2'd2};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0C, 2'd1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0C, 2'd0};
    vecs[7]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0C, 2'd0};
    vecs[8]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0C, 2'd1};
    vecs[9]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0C, 2'd2};
    vecs[10] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 2'd3};
    vecs[11] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 2'd3};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 2'd3};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 2'd2};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 2'd1};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04, 2'd0};

    nRST = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(negedge CLK); #1;
    chk("rst_in_ready", 32'(ir3), 32'(1'b0));
    chk("rst_out_valid", 32'(ov3), 32'(1'b0));
    chk("rst_out_data", 32'(od3), 32'(8'hEE));
    chk("rst_count", 32'(cnt3), 32'(2'd0));
    @(negedge CLK);
    nRST = 1'b1;

    for (int k = 0; k < NV; k++) begin
      step(vecs[k].iv, vecs[k].d, vecs[k].ordy, vecs[k].e, vecs[k].fl);
      chk($sformatf("vec%0d_in_ready", k), 32'(ir3), 32'(vecs[k].e_ir));
      chk($sformatf("vec%0d_out_valid", k), 32'(ov3), 32'(vecs[k].e_ov));
      chk($sformatf("vec%0d_out_data", k), 32'(od3), 32'(vecs[k].e_od));
      chk($sformatf("vec%0d_count", k), 32'(cnt3), 32'(vecs[k].e_cnt));
    end

    // DEPTH=4 bubble collapse and latency
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("bub_push1_ready", 32'(ir4), 32'(1'b1));
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("bub_lat0", 32'(ov4), 32'(1'b0));
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("bub_lat1", 32'(ov4), 32'(1'b0));
    step(1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    chk("bub_lat2", 32'(ov4), 32'(1'b0));
    chk("bub_push2_ready", 32'(ir4), 32'(1'b1));
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("bub_lat3_valid", 32'(ov4), 32'(1'b1));
    chk("bub_lat3_data", 32'(od4), 32'(8'h01));
    chk("bub_lat3_count", 32'(cnt4), 32'(3'd2));
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("bub_settle_count", 32'(cnt4), 32'(3'd2));
    chk("bub_settle_ready", 32'(ir4), 32'(1'b1));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("bub_drain0_valid", 32'(ov4), 32'(1'b1));
    chk("bub_drain0_data", 32'(od4), 32'(8'h01));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("bub_drain1_valid", 32'(ov4), 32'(1'b1));
    chk("bub_drain1_data", 32'(od4), 32'(8'h02));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("bub_empty_valid", 32'(ov4), 32'(1'b0));
    chk("bub_empty_count", 32'(cnt4), 32'(3'd0));

    // DEPTH=3 global hold with 0x5, 0x6 in flight
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h06, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
      chk($sformatf("hold%0d_in_ready", k), 32'(ir3), 32'(1'b0));
      chk($sformatf("hold%0d_out_valid", k), 32'(ov3), 32'(1'b0));
      chk($sformatf("hold%0d_out_data", k), 32'(od3), 32'(8'h05));
      chk($sformatf("hold%0d_count", k), 32'(cnt3), 32'(2'd2));
    end
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("hold_release_valid", 32'(ov3), 32'(1'b1));
    chk("hold_release_data", 32'(od3), 32'(8'h05));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("hold_next_data", 32'(od3), 32'(8'h06));
    chk("hold_next_count", 32'(cnt3), 32'(2'd1));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("hold_drained", 32'(ov3), 32'(1'b0));

    // DEPTH=3 flush over a full chain with both handshakes offered
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h13, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h14, 1'b1, 1'b1, 1'b1);
    chk("flush_in_ready", 32'(ir3), 32'(1'b0));
    chk("flush_out_valid", 32'(ov3), 32'(1'b0));
    chk("flush_pre_count", 32'(cnt3), 32'(2'd3));
    step(1'b1, 8'h09, 1'b1, 1'b1, 1'b0);
    chk("flush_post_count", 32'(cnt3), 32'(2'd0));
    chk("flush_post_valid", 32'(ov3), 32'(1'b0));
    chk("flush_payload_held", 32'(od3), 32'(8'h11));
    chk("flush_push_ready", 32'(ir3), 32'(1'b1));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("flush_lat0", 32'(ov3), 32'(1'b0));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("flush_lat1", 32'(ov3), 32'(1'b0));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("flush_emerge_valid", 32'(ov3), 32'(1'b1));
    chk("flush_emerge_data", 32'(od3), 32'(8'h09));

    // DEPTH=2 asynchronous reset mid-stream
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h21, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("arst_pre_count", 32'(cnt2), 32'(2'd2));
    chk("arst_pre_data", 32'(od2), 32'(8'h21));
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov2), 32'(1'b0));
    chk("arst_out_data", 32'(od2), 32'(8'hEE));
    chk("arst_count", 32'(cnt2), 32'(2'd0));
    chk("arst_in_ready", 32'(ir2), 32'(1'b0));
    @(negedge CLK);
    nRST = 1'b1;
    step(1'b1, 8'h23, 1'b1, 1'b1, 1'b0);
    chk("arst_resume_ready", 32'(ir2), 32'(1'b1));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("arst_resume_lat", 32'(ov2), 32'(1'b0));
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("arst_resume_valid", 32'(ov2), 32'(1'b1));
    chk("arst_resume_data", 32'(od2), 32'(8'h23));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
